// File: rtl/pll_drp_reconfig_ctrl_if.sv
// rtl/pll_drp_reconfig_ctrl_if.sv - table, DRP and status signals of the PLL reconfiguration controller
interface pll_drp_reconfig_ctrl_if #(
  parameter int TBL_AW = 6
);
  logic              start;
  logic [TBL_AW-1:0] tbl_base;
  logic [TBL_AW-1:0] tbl_addr;
  logic [4:0]        tbl_daddr;
  logic [15:0]       tbl_mask;
  logic [15:0]       tbl_data;
  logic              tbl_last;
  logic [4:0]        daddr;
  logic [15:0]       di;
  logic              den;
  logic              dwe;
  logic [15:0]       drp_do;
  logic              drdy;
  logic              pll_rst;
  logic              pll_locked;
  logic              busy;
  logic              done;
  logic              error;

  modport master (
    input  start, tbl_base, tbl_daddr, tbl_mask, tbl_data, tbl_last, drp_do, drdy, pll_locked,
    output tbl_addr, daddr, di, den, dwe, pll_rst, busy, done, error
  );

  modport slave (
    output start, tbl_base, tbl_daddr, tbl_mask, tbl_data, tbl_last, drp_do, drdy, pll_locked,
    input  tbl_addr, daddr, di, den, dwe, pll_rst, busy, done, error
  );
endinterface

// File: rtl/pll_drp_reconfig_ctrl.sv
// rtl/pll_drp_reconfig_ctrl.sv - DRP read-modify-write sequencer that reprograms a PLL from a table
module pll_drp_reconfig_ctrl #(
  parameter int TBL_AW       = 6,
  parameter int DRDY_TIMEOUT = 15,
  parameter int RST_HOLD     = 4,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic                          clk,
  input  logic                          reset,
  pll_drp_reconfig_ctrl_if.master       bus
);
  localparam int MAX_A   = (DRDY_TIMEOUT > RST_HOLD) ? DRDY_TIMEOUT : RST_HOLD;
  localparam int CNT_MAX = (LOCK_TIMEOUT > MAX_A) ? LOCK_TIMEOUT : MAX_A;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] DRDY_END = CW'(DRDY_TIMEOUT - 1);
  localparam logic [CW-1:0] HOLD_END = CW'(RST_HOLD - 1);
  localparam logic [CW-1:0] LOCK_END = CW'(LOCK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_RD_REQ, S_RD_WAIT, S_WR_REQ, S_WR_WAIT, S_HOLD, S_LOCK_WAIT
  } state_t;

  state_t            state_q, state_d;
  logic [TBL_AW-1:0] tbl_addr_q, tbl_addr_d;
  logic [4:0]        daddr_q, daddr_d;
  logic [15:0]       di_q, di_d, mask_q, mask_d, data_q, data_d;
  logic              last_q, last_d;
  logic              den_q, den_d, dwe_q, dwe_d;
  logic              pll_rst_q, pll_rst_d, busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      tbl_addr_q <= '0;
      daddr_q    <= '0;
      di_q       <= '0;
      mask_q     <= '0;
      data_q     <= '0;
      last_q     <= 1'b0;
      den_q      <= 1'b0;
      dwe_q      <= 1'b0;
      pll_rst_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      tbl_addr_q <= tbl_addr_d;
      daddr_q    <= daddr_d;
      di_q       <= di_d;
      mask_q     <= mask_d;
      data_q     <= data_d;
      last_q     <= last_d;
      den_q      <= den_d;
      dwe_q      <= dwe_d;
      pll_rst_q  <= pll_rst_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tbl_addr_d = tbl_addr_q;
    daddr_d    = daddr_q;
    di_d       = di_q;
    mask_d     = mask_q;
    data_d     = data_q;
    last_d     = last_q;
    den_d      = 1'b0;
    dwe_d      = 1'b0;
    pll_rst_d  = pll_rst_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    error_d    = error_q;
    cnt_d      = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          tbl_addr_d = bus.tbl_base;
          error_d    = 1'b0;
          busy_d     = 1'b1;
          pll_rst_d  = 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_FETCH: state_d = S_RD_REQ;
      S_RD_REQ: begin
        mask_d  = bus.tbl_mask;
        data_d  = bus.tbl_data;
        last_d  = bus.tbl_last;
        daddr_d = bus.tbl_daddr;
        den_d   = 1'b1;
        cnt_d   = '0;
        state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (bus.drdy) begin
          di_d    = (bus.drp_do & mask_q) | (data_q & ~mask_q);
          state_d = S_WR_REQ;
        end else if (cnt_q == DRDY_END) begin
          error_d   = 1'b1;
          pll_rst_d = 1'b0;
          busy_d    = 1'b0;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WR_REQ: begin
        den_d   = 1'b1;
        dwe_d   = 1'b1;
        cnt_d   = '0;
        state_d = S_WR_WAIT;
      end
      S_WR_WAIT: begin
        if (bus.drdy) begin
          cnt_d = '0;
          if (last_q) begin
            state_d = S_HOLD;
          end else begin
            tbl_addr_d = tbl_addr_q + TBL_AW'(1);
            state_d    = S_FETCH;
          end
        end else if (cnt_q == DRDY_END) begin
          error_d   = 1'b1;
          pll_rst_d = 1'b0;
          busy_d    = 1'b0;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_HOLD: begin
        // lock counter starts from zero on the same edge that releases reset
        if (cnt_q == HOLD_END) begin
          pll_rst_d = 1'b0;
          cnt_d     = '0;
          state_d   = S_LOCK_WAIT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_LOCK_WAIT: begin
        if (bus.pll_locked) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else if (cnt_q == LOCK_END) begin
          error_d = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.tbl_addr = tbl_addr_q;
  assign bus.daddr    = daddr_q;
  assign bus.di       = di_q;
  assign bus.den      = den_q;
  assign bus.dwe      = dwe_q;
  assign bus.pll_rst  = pll_rst_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.error    = error_q;
endmodule

// File: tb/tb_pll_drp_reconfig_ctrl.sv
// tb/tb_pll_drp_reconfig_ctrl.sv - directed bench with table ROM, DRP register and PLL lock models
module tb_pll_drp_reconfig_ctrl;
  localparam int TBL_AW = 6;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pll_drp_reconfig_ctrl_if #(.TBL_AW(TBL_AW)) bus ();

  pll_drp_reconfig_ctrl #(
    .TBL_AW(TBL_AW), .DRDY_TIMEOUT(15), .RST_HOLD(4), .LOCK_TIMEOUT(65535)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  logic [4:0]  rom_daddr [64];
  logic [15:0] rom_mask  [64];
  logic [15:0] rom_data  [64];
  logic        rom_last  [64];
  logic [15:0] regs      [32];

  always @(posedge clk) begin
    bus.tbl_daddr <= rom_daddr[bus.tbl_addr];
    bus.tbl_mask  <= rom_mask[bus.tbl_addr];
    bus.tbl_data  <= rom_data[bus.tbl_addr];
    bus.tbl_last  <= rom_last[bus.tbl_addr];
  end

  int drdy_delay = 2;
  int lock_delay = 10;
  int drop_at = -1;

  int cyc = 0, rd_cnt = 0, wr_cnt = 0, den_cnt = 0, done_cnt = 0, rise_cnt = 0, viol_cnt = 0;
  int den_cyc = 0, wr_drdy_cyc = 0, release_cyc = 0, done_cyc = 0, err_cyc = 0;
  int pend = 0, lcnt = 0;
  bit pend_wr = 1'b0, outstanding = 1'b0;
  logic [4:0] pend_addr = '0;
  logic prev_rst = 1'b0, prev_err = 1'b0;
  int addr_log[$];
  int wr_addr_log[$];
  int wr_data_log[$];

  // Monitor first, then the DRP and lock models, all at mid-cycle
  always @(negedge clk) begin
    cyc++;
    if (bus.done === 1'b1) begin done_cnt++; done_cyc = cyc; end
    if (bus.error === 1'b1 && !prev_err) err_cyc = cyc;
    if (bus.pll_rst === 1'b1 && !prev_rst) rise_cnt++;
    if (bus.pll_rst === 1'b0 && prev_rst) release_cyc = cyc;
    prev_rst = (bus.pll_rst === 1'b1);
    prev_err = (bus.error === 1'b1);
    if (reset || bus.error === 1'b1) outstanding = 1'b0;

    bus.drdy = 1'b0;
    if (bus.den === 1'b1) begin
      den_cnt++;
      den_cyc = cyc;
      if (outstanding) viol_cnt++;
      outstanding = 1'b1;
      pend_addr = bus.daddr;
      pend_wr = bus.dwe;
      if (bus.dwe === 1'b1) begin
        wr_cnt++;
        wr_addr_log.push_back(int'(bus.daddr));
        wr_data_log.push_back(int'(bus.di));
        pend = drdy_delay;
      end else begin
        rd_cnt++;
        addr_log.push_back(int'(bus.tbl_addr));
        pend = (rd_cnt == drop_at) ? 0 : drdy_delay;
      end
    end else if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        bus.drdy = 1'b1;
        outstanding = 1'b0;
        if (pend_wr) wr_drdy_cyc = cyc;
        else bus.drp_do = regs[pend_addr];
      end
    end

    if (bus.pll_rst !== 1'b0 || bus.pll_locked === 1'bx) begin
      bus.pll_locked = 1'b0;
      lcnt = 0;
    end else if (lock_delay >= 0 && !bus.pll_locked) begin
      lcnt++;
      if (lcnt >= lock_delay) bus.pll_locked = 1'b1;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic run_start(input logic [TBL_AW-1:0] base);
    tick();
    bus.start = 1'b1;
    bus.tbl_base = base;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (bus.busy === 1'b0) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic set_entry(input int a, input logic [4:0] da, input logic [15:0] m,
                           input logic [15:0] d, input logic l);
    rom_daddr[a] = da; rom_mask[a] = m; rom_data[a] = d; rom_last[a] = l;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    checks++;
    if ({bus.busy, bus.done, bus.error, bus.pll_rst, bus.den, bus.dwe} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 000000", {bus.busy, bus.done, bus.error, bus.pll_rst, bus.den, bus.dwe});
    end
    checks++;
    if ({bus.tbl_addr, bus.daddr, bus.di} !== '0) begin
      errors++;
      $display("FAIL reset_addr: tbl_addr=%0d daddr=%0h di=%0h want 0", bus.tbl_addr, bus.daddr, bus.di);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single();
    int rd0 = rd_cnt, wr0 = wr_cnt, dn0 = done_cnt, ri0 = rise_cnt, wq = wr_data_log.size();
    bit ok;
    set_entry(5, 5'h0A, 16'hF000, 16'h0123, 1'b1);
    regs[5'h0A] = 16'hABCD;
    drdy_delay = 2; lock_delay = 10;
    run_start(6'd5);
    wait_idle(300, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_finish: busy=%b want 0", bus.busy); end
    checks++;
    if (rd_cnt - rd0 != 1 || wr_cnt - wr0 != 1) begin
      errors++; $display("FAIL single_den_count: rd=%0d wr=%0d want 1 1", rd_cnt - rd0, wr_cnt - wr0);
    end
    checks++;
    if (wr_data_log.size() != wq + 1 || wr_addr_log[wq] != 'h0A || wr_data_log[wq] != 'hA123) begin
      errors++; $display("FAIL single_write: size=%0d want %0d, addr/data want 0a/a123", wr_data_log.size(), wq + 1);
    end
    checks++;
    if (release_cyc - wr_drdy_cyc != 5) begin
      errors++; $display("FAIL single_hold: release-drdy=%0d want 5", release_cyc - wr_drdy_cyc);
    end
    checks++;
    if (done_cyc - release_cyc != 10) begin
      errors++; $display("FAIL single_lock: done-release=%0d want 10", done_cyc - release_cyc);
    end
    checks++;
    if (done_cnt - dn0 != 1 || bus.error !== 1'b0 || rise_cnt - ri0 != 1) begin
      errors++; $display("FAIL single_status: done=%0d err=%b rst_rises=%0d want 1 0 1", done_cnt - dn0, bus.error, rise_cnt - ri0);
    end
  endtask

  task automatic test_wrap();
    int rd0 = rd_cnt, wr0 = wr_cnt, dn0 = done_cnt, aq = addr_log.size(), wq = wr_data_log.size();
    bit ok;
    set_entry(62, 5'h01, 16'h00FF, 16'h1234, 1'b0);
    set_entry(63, 5'h02, 16'hFFFF, 16'hBEEF, 1'b0);
    set_entry(0,  5'h1F, 16'h0000, 16'hCAFE, 1'b1);
    regs[5'h01] = 16'h5678; regs[5'h02] = 16'h0F0F; regs[5'h1F] = 16'h1111;
    run_start(6'd62);
    wait_idle(500, ok);
    checks++;
    if (!ok || done_cnt - dn0 != 1) begin errors++; $display("FAIL wrap_done: ok=%b done=%0d want 1 1", ok, done_cnt - dn0); end
    checks++;
    if (rd_cnt - rd0 != 3 || wr_cnt - wr0 != 3) begin
      errors++; $display("FAIL wrap_den_count: rd=%0d wr=%0d want 3 3", rd_cnt - rd0, wr_cnt - wr0);
    end
    checks++;
    if (addr_log.size() != aq + 3 || addr_log[aq] != 62 || addr_log[aq+1] != 63 || addr_log[aq+2] != 0) begin
      errors++; $display("FAIL wrap_tbl_addr: entries=%0d want %0d with 62,63,0", addr_log.size() - aq, 3);
    end
    checks++;
    if (wr_data_log.size() != wq + 3 || wr_data_log[wq] != 'h1278 || wr_data_log[wq+1] != 'h0F0F
        || wr_data_log[wq+2] != 'hCAFE || wr_addr_log[wq+2] != 'h1F) begin
      errors++; $display("FAIL wrap_write_data: entries=%0d want 3 with 1278,0f0f,cafe", wr_data_log.size() - wq);
    end
    checks++;
    if (viol_cnt != 0) begin errors++; $display("FAIL den_outstanding: violations=%0d want 0", viol_cnt); end
  endtask

  task automatic test_drdy_timeout();
    int wr0 = wr_cnt, dn0 = done_cnt;
    bit ok;
    set_entry(10, 5'h03, 16'hFFFF, 16'h0000, 1'b0);
    set_entry(11, 5'h04, 16'hFFFF, 16'h0000, 1'b1);
    set_entry(20, 5'h05, 16'hFFFF, 16'h0000, 1'b1);
    drop_at = rd_cnt + 2;
    run_start(6'd10);
    wait_idle(300, ok);
    checks++;
    if (!ok || err_cyc - den_cyc != 15) begin
      errors++; $display("FAIL drdy_timeout_time: ok=%b err-den=%0d want 15", ok, err_cyc - den_cyc);
    end
    checks++;
    if (bus.error !== 1'b1 || bus.pll_rst !== 1'b0 || bus.busy !== 1'b0 || done_cnt != dn0) begin
      errors++; $display("FAIL drdy_timeout_state: err=%b rst=%b busy=%b done=%0d want 1 0 0 0", bus.error, bus.pll_rst, bus.busy, done_cnt - dn0);
    end
    checks++;
    if (wr_cnt - wr0 != 1) begin errors++; $display("FAIL drdy_timeout_writes: got %0d want 1", wr_cnt - wr0); end
    drop_at = -1;
    run_start(6'd20);
    checks++;
    if (bus.error !== 1'b0 || bus.busy !== 1'b1) begin
      errors++; $display("FAIL error_clear: err=%b busy=%b want 0 1", bus.error, bus.busy);
    end
    wait_idle(300, ok);
    checks++;
    if (!ok || done_cnt - dn0 != 1 || bus.error !== 1'b0) begin
      errors++; $display("FAIL after_error_run: ok=%b done=%0d err=%b want 1 1 0", ok, done_cnt - dn0, bus.error);
    end
  endtask

  task automatic test_lock_timeout();
    int dn0 = done_cnt;
    bit ok;
    set_entry(30, 5'h06, 16'h0000, 16'h5555, 1'b1);
    lock_delay = -1;
    run_start(6'd30);
    wait_idle(70000, ok);
    checks++;
    if (!ok || err_cyc - release_cyc != 65535) begin
      errors++; $display("FAIL lock_timeout_time: ok=%b err-release=%0d want 65535", ok, err_cyc - release_cyc);
    end
    checks++;
    if (bus.error !== 1'b1 || bus.pll_rst !== 1'b0 || done_cnt != dn0) begin
      errors++; $display("FAIL lock_timeout_state: err=%b rst=%b done=%0d want 1 0 0", bus.error, bus.pll_rst, done_cnt - dn0);
    end
    lock_delay = 10;
  endtask

  task automatic test_start_ignored();
    int rd0 = rd_cnt, wr0 = wr_cnt, dn0 = done_cnt, wq = wr_data_log.size();
    bit ok, seen;
    set_entry(40, 5'h07, 16'h0F0F, 16'h1234, 1'b1);
    set_entry(41, 5'h08, 16'h0000, 16'h9999, 1'b1);
    regs[5'h07] = 16'hAAAA;
    drdy_delay = 6;
    run_start(6'd40);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (wr_cnt > wr0) begin seen = 1'b1; break; end
      tick();
    end
    run_start(6'd41);
    wait_idle(300, ok);
    repeat (30) tick();
    checks++;
    if (!seen || !ok) begin errors++; $display("FAIL start_busy_flow: write_seen=%b ok=%b want 1 1", seen, ok); end
    checks++;
    if (done_cnt - dn0 != 1 || rd_cnt - rd0 != 1 || wr_cnt - wr0 != 1 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL start_busy_ignored: done=%0d rd=%0d wr=%0d busy=%b want 1 1 1 0", done_cnt - dn0, rd_cnt - rd0, wr_cnt - wr0, bus.busy);
    end
    checks++;
    if (wr_data_log.size() != wq + 1 || wr_data_log[wq] != 'h1A3A) begin
      errors++; $display("FAIL start_busy_data: entries=%0d want 1 with 1a3a", wr_data_log.size() - wq);
    end
    drdy_delay = 2;
  endtask

  task automatic test_reset_midseq();
    int rd0 = rd_cnt, d0;
    bit seen;
    set_entry(50, 5'h09, 16'h0000, 16'hFFFF, 1'b1);
    drdy_delay = 6;
    run_start(6'd50);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (rd_cnt > rd0) begin seen = 1'b1; break; end
      tick();
    end
    tick();
    reset = 1'b1;
    tick();
    checks++;
    if (!seen || {bus.busy, bus.done, bus.error, bus.pll_rst, bus.den, bus.dwe} !== 6'b0) begin
      errors++; $display("FAIL midseq_reset_ctrl: read_seen=%b outputs=%b want 1 000000", seen, {bus.busy, bus.done, bus.error, bus.pll_rst, bus.den, bus.dwe});
    end
    checks++;
    if ({bus.tbl_addr, bus.daddr, bus.di} !== '0) begin
      errors++; $display("FAIL midseq_reset_addr: tbl_addr=%0d daddr=%0h di=%0h want 0", bus.tbl_addr, bus.daddr, bus.di);
    end
    reset = 1'b0;
    d0 = den_cnt;
    repeat (12) tick();
    checks++;
    if (den_cnt != d0 || bus.di !== 16'h0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL late_drdy_ignored: den=%0d di=%0h busy=%b want 0 0 0", den_cnt - d0, bus.di, bus.busy);
    end
    drdy_delay = 2;
  endtask

  initial begin
    bus.start = 1'b0;
    bus.tbl_base = '0;
    for (int i = 0; i < 64; i++) set_entry(i, 5'h00, 16'hFFFF, 16'h0000, 1'b1);
    for (int i = 0; i < 32; i++) regs[i] = 16'h0000;
    test_reset();
    test_single();
    test_wrap();
    test_drdy_timeout();
    test_lock_timeout();
    test_start_ignored();
    test_reset_midseq();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pll_drp_reconfig_ctrl.md
Name: pll_drp_reconfig_ctrl

Overview:
- Sequences run-time reprogramming of one Spartan-6 PLL_ADV through its DRP port, so on-chip clocks (core, compare, word-gen) can change frequency without a rebuild.
- Walks a table of (DRP address, keep-mask, data) entries in external synchronous ROM/RAM, doing read-modify-write per entry while holding the PLL in reset. Then releases reset and waits for lock.
- Sits beside the clock-generation module; runs on the input clock domain, never on a PLL output.

Parameters:
TBL_AW, 6, table address width
DRDY_TIMEOUT, 15, max cycles waiting for DRDY after DEN before error
RST_HOLD, 4, cycles PLL_RST held after last write before release
LOCK_TIMEOUT, 65535, max cycles waiting for PLL_LOCKED after release before error

Ports:
CLK  in  1  controller and DRP clock (DCLK)
RESET  in  1  synchronous, active-high
START  in  1  single-cycle request; ignored unless idle
TBL_BASE  in  TBL_AW  first table entry of the sequence, sampled with START
TBL_ADDR  out  TBL_AW  table read address
TBL_DADDR  in  5  DRP address of entry, valid 1 cycle after TBL_ADDR
TBL_MASK  in  16  bits set = keep current register bit
TBL_DATA  in  16  new bits (used where mask = 0)
TBL_LAST  in  1  entry is last of sequence
DADDR  out  5  to PLL DADDR
DI  out  16  to PLL DI
DEN  out  1  to PLL DEN
DWE  out  1  to PLL DWE
DO  in  16  from PLL DO
DRDY  in  1  from PLL DRDY
PLL_RST  out  1  to PLL RST
PLL_LOCKED  in  1  from PLL LOCKED
BUSY  out  1  sequence in progress
DONE  out  1  one-cycle pulse on success
ERROR  out  1  sticky; set on timeout, cleared by next accepted START or RESET

Behaviour:
- Reset: state IDLE; DEN=DWE=0, DADDR=0, DI=0, TBL_ADDR=0, PLL_RST=0, BUSY=0, DONE=0, ERROR=0, counters 0.
- Reset mid-sequence aborts immediately to the same values. PLL_RST drops to 0 (PLL relocks on its old or partial config); in-flight DRDY is ignored.
- All outputs registered. Table read latency exactly 1 cycle.
- States:
  - IDLE: on START: TBL_ADDR<=TBL_BASE, ERROR<=0, BUSY<=1, PLL_RST<=1, -> FETCH.
  - FETCH: 1 cycle (table latency) -> RD_REQ.
  - RD_REQ: latch TBL_DADDR/MASK/DATA/LAST; DADDR<=TBL_DADDR; DEN=1 for exactly 1 cycle, DWE=0 -> RD_WAIT.
  - RD_WAIT: on DRDY: DI<=(DO & MASK) | (DATA & ~MASK) -> WR_REQ.
  - WR_REQ: DEN=1, DWE=1 for exactly 1 cycle -> WR_WAIT.
  - WR_WAIT: on DRDY: if LAST -> HOLD, else TBL_ADDR<=TBL_ADDR+1 (wraps modulo 2^TBL_AW) -> FETCH.
  - HOLD: count RST_HOLD cycles with PLL_RST=1, then PLL_RST<=0 -> LOCK_WAIT.
  - LOCK_WAIT: on PLL_LOCKED=1: DONE pulse, BUSY<=0 -> IDLE.
  - Timeout in RD_WAIT/WR_WAIT (counter reaches DRDY_TIMEOUT without DRDY): ERROR<=1, PLL_RST<=0, BUSY<=0, no DONE -> IDLE.
  - Timeout in LOCK_WAIT (LOCK_TIMEOUT cycles): same as DRDY timeout.
- DRDY wait counter restarts at each DEN; lock counter starts at PLL_RST release.
- PLL_LOCKED already high in the first LOCK_WAIT cycle counts as locked. The PLL drops LOCKED during reset, so the stale level is acceptable.
- DRDY outside RD_WAIT/WR_WAIT is ignored. START while BUSY is ignored (no queueing).
- DEN never asserted while a prior DRP access is outstanding.
- PLL_RST stays high continuously from START acceptance through the end of HOLD.

Test Plan:
- 1-entry table {DADDR=0x0A, MASK=0xF000, DATA=0x0123, LAST=1}, DO=0xABCD, DRDY 2 cycles after each DEN, LOCKED 10 cycles after release -> read then write to 0x0A with DI=0xA123; PLL_RST high through 4 HOLD cycles; DONE 1 pulse; ERROR=0.
- 3-entry table at TBL_BASE=62 (TBL_AW=6) -> TBL_ADDR sequence 62,63,0; exactly 3 read and 3 write DEN pulses; DONE.
- DRDY never returns on second read -> ERROR=1 exactly 15 cycles after that DEN; PLL_RST=0; BUSY=0; no DONE. Next START clears ERROR.
- LOCKED held low -> ERROR after 65535 cycles of LOCK_WAIT; no DONE.
- START pulsed during WR_WAIT -> ignored; sequence completes once; single DONE.
- RESET asserted in RD_WAIT with late DRDY arriving afterwards -> all outputs return to reset values next cycle; spurious DRDY causes no DEN/DI change.
